// File: rtl/bht_predictor.sv
// Branch history table: NR_ROWS x INSTR_PER_FETCH 2-bit saturating counters,
// each with a valid bit. Combinational lookup by fetch PC, single-entry
// training per cycle from resolved conditional branches.
module bht_predictor #(
   parameter int unsigned VLEN            = 64,
   parameter int unsigned NR_ENTRIES      = 128,
   parameter int unsigned INSTR_PER_FETCH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_bp_i,
   input  logic                       debug_mode_i,
   input  logic [VLEN-1:0]            vpc_i,
   input  logic                       bht_update_valid_i,
   input  logic [VLEN-1:0]            bht_update_pc_i,
   input  logic                       bht_update_taken_i,
   output logic [INSTR_PER_FETCH-1:0] bht_valid_o,
   output logic [INSTR_PER_FETCH-1:0] bht_taken_o
);

   localparam int unsigned NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned ROW_W   = $clog2(NR_ROWS);
   localparam int unsigned CB      = $clog2(INSTR_PER_FETCH);
   // Flat entry index = row * INSTR_PER_FETCH + column, which is exactly
   // pc[1 +: ROW_W+CB] because the column bits sit directly below the row bits.
   localparam int unsigned IDX_W   = ROW_W + CB;

   logic [NR_ENTRIES-1:0]      valid_q;
   logic [NR_ENTRIES-1:0][1:0] ctr_q;

   logic [IDX_W-1:0] upd_idx;
   logic [ROW_W-1:0] look_row;
   logic [1:0]       upd_ctr;
   logic             upd_en;

   // Only the index bits of the PCs matter; pc[0] and the upper bits are dropped.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{vpc_i, bht_update_pc_i};

   assign upd_idx  = bht_update_pc_i[1 +: IDX_W];
   assign look_row = vpc_i[1+CB +: ROW_W];
   assign upd_en   = bht_update_valid_i & ~debug_mode_i & ~flush_bp_i;

   // Saturating up/down step of a 2-bit counter; never wraps.
   function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
      else
         return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
   endfunction

   // Next counter value for the addressed entry; a fresh entry starts weakly biased.
   always_comb begin
      upd_ctr = 2'b00;
      if (valid_q[upd_idx])
         upd_ctr = sat_step(ctr_q[upd_idx], bht_update_taken_i);
      else
         upd_ctr = bht_update_taken_i ? 2'b10 : 2'b01;
   end

   // Table state: reset and flush clear everything, otherwise train one entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         ctr_q   <= '0;
      end else if (flush_bp_i) begin
         valid_q <= '0;
         ctr_q   <= '0;
      end else if (upd_en) begin
         valid_q[upd_idx] <= 1'b1;
         ctr_q[upd_idx]   <= upd_ctr;
      end
   end

   // Per-column combinational read of the row selected by the fetch PC.
   genvar c;
   generate
      for (c = 0; c < INSTR_PER_FETCH; c++) begin : g_col
         logic [IDX_W-1:0] look_idx;
         assign look_idx       = (IDX_W'(look_row) << CB) | IDX_W'(c);
         assign bht_valid_o[c] = valid_q[look_idx];
         assign bht_taken_o[c] = ctr_q[look_idx][1];
      end
   endgenerate

endmodule
